// File: rtl/credit_sched_pkg.sv
// Shared types and default sizing for the credit scheduler.
// Used by credit_counter and credit_sched (optional CREDIT_SCHED_AGING_EN lives in the top).
package credit_sched_pkg;

    localparam int NUM_REQ_DEF   = 4;
    localparam int WIDTH_DEF     = 4;
    localparam int AMT_W_DEF     = 2;
    localparam int AGE_LIMIT_DEF = 8;

    typedef logic [WIDTH_DEF-1:0] credit_t;
    typedef logic [AMT_W_DEF-1:0] amt_t;

    localparam credit_t CREDIT_MAX = '1;

endpackage

// File: rtl/credit_sched_counter.sv
// Saturating up/down credit register with sticky return-overflow flag.
// Reinit reloads from initial_value and ignores returns that cycle.
module credit_counter
    import credit_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reinit,
    input  logic [WIDTH-1:0] initial_value,
    input  logic             dec_valid,
    input  logic [AMT_W-1:0] dec_amt,
    input  logic             ret_valid,
    input  logic [AMT_W-1:0] ret_amt,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] value_next,
    output logic             ovf
);

    logic [WIDTH:0]   w_sum;
    logic             w_ovf_set;
    logic [WIDTH-1:0] r_value;
    logic             r_ovf;

    // Next count: dec never exceeds value (grant requires eligibility), so only the top can overflow.
    always_comb begin
        w_sum      = {1'b0, r_value};
        w_ovf_set  = 1'b0;
        value_next = r_value;
        if (reinit) begin
            value_next = initial_value;
        end else begin
            w_sum = {1'b0, r_value}
                  - (dec_valid ? (WIDTH+1)'(dec_amt) : {(WIDTH+1){1'b0}})
                  + (ret_valid ? (WIDTH+1)'(ret_amt) : {(WIDTH+1){1'b0}});
            if (w_sum[WIDTH]) begin
                value_next = {WIDTH{1'b1}};
                w_ovf_set  = 1'b1;
            end else begin
                value_next = w_sum[WIDTH-1:0];
            end
        end
    end

    // Credit and overflow registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_value <= initial_value;
            r_ovf   <= 1'b0;
        end else begin
            r_value <= value_next;
            r_ovf   <= reinit ? 1'b0 : (r_ovf | w_ovf_set);
        end
    end

    assign value = r_value;
    assign ovf   = r_ovf;

endmodule

// File: rtl/credit_sched.sv
// Round-robin credit scheduler: grants one eligible requester per cycle against a credit pool.
// Define CREDIT_SCHED_AGING_EN to add per-requester wait counters and starvation priority.
module credit_sched
    import credit_sched_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int AMT_W     = AMT_W_DEF,
    parameter int AGE_LIMIT = AGE_LIMIT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reinit,
    input  logic [WIDTH-1:0]         initial_value,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*AMT_W-1:0] req_amt,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     ret_valid,
    input  logic [AMT_W-1:0]         ret_amt,
    output logic [WIDTH-1:0]         value,
    output logic [WIDTH-1:0]         value_next,
    output logic                     ovf,
    output logic [NUM_REQ-1:0]       starved
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_cand;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic [NUM_REQ-1:0] w_ready;
    logic [AMT_W-1:0]   w_grant_amt;
    logic               w_found;

    // Eligibility uses the registered count only, so same-cycle returns cannot help.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_eligible[i] = req_valid[i] && (WIDTH'(req_amt[i*AMT_W +: AMT_W]) <= value);
        end
    end

`ifdef CREDIT_SCHED_AGING_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);

    logic [AGE_W-1:0]   r_age [NUM_REQ];
    logic [AGE_W-1:0]   w_age_next [NUM_REQ];
    logic [NUM_REQ-1:0] r_starved;
    logic [NUM_REQ-1:0] w_starve_pick;
    logic               w_pick_done;

    // Lowest-index starved requester becomes the sole candidate.
    always_comb begin
        w_starve_pick = '0;
        w_pick_done   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_starved[i] && !w_pick_done) begin
                w_starve_pick[i] = 1'b1;
                w_pick_done      = 1'b1;
            end else begin
                w_starve_pick[i] = 1'b0;
            end
        end
        w_cand = w_pick_done ? (w_eligible & w_starve_pick) : w_eligible;
    end

    // Wait counters: count ungranted valid cycles, saturating at the starvation limit.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_ready[i] || !req_valid[i]) begin
                w_age_next[i] = '0;
            end else if (r_age[i] < AGE_W'(AGE_LIMIT)) begin
                w_age_next[i] = r_age[i] + AGE_W'(1);
            end else begin
                w_age_next[i] = r_age[i];
            end
        end
    end

    // Age and starvation registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst || reinit) begin
                r_age[i]     <= '0;
                r_starved[i] <= 1'b0;
            end else begin
                r_age[i]     <= w_age_next[i];
                r_starved[i] <= (w_age_next[i] == AGE_W'(AGE_LIMIT));
            end
        end
    end

    assign starved = r_starved;
`else
    assign w_cand  = w_eligible;
    assign starved = '0;
`endif

    // Round-robin search starting one past the last granted index.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = r_ptr;
        w_found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_cand[(int'(r_ptr) + 1 + k) % NUM_REQ]) begin
                w_found     = 1'b1;
                w_grant_idx = IDX_W'((int'(r_ptr) + 1 + k) % NUM_REQ);
                w_grant[(int'(r_ptr) + 1 + k) % NUM_REQ] = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
        w_ready     = (rst && !reinit) ? w_grant : '0;
        w_grant_amt = req_amt[int'(w_grant_idx)*AMT_W +: AMT_W];
    end

    // Pointer moves only on an actual transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= IDX_W'(NUM_REQ - 1);
        end else if (|w_ready) begin
            r_ptr <= w_grant_idx;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign req_ready = w_ready;

    credit_counter #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_credit_counter (
        .clk           (clk),
        .rst           (rst),
        .reinit        (reinit),
        .initial_value (initial_value),
        .dec_valid     (|w_ready),
        .dec_amt       (w_grant_amt),
        .ret_valid     (ret_valid),
        .ret_amt       (ret_amt),
        .value         (value),
        .value_next    (value_next),
        .ovf           (ovf)
    );

endmodule

// File: tb/tb_credit_sched.sv
// Directed self-checking bench for credit_sched (default parameters).
// Starvation steps run only when CREDIT_SCHED_AGING_EN is defined.
module tb_credit_sched;

    logic       clk;
    logic       rst;
    logic       reinit;
    logic [3:0] initial_value;
    logic [3:0] req_valid;
    logic [7:0] req_amt;
    logic [3:0] req_ready;
    logic       ret_valid;
    logic [1:0] ret_amt;
    logic [3:0] value;
    logic [3:0] value_next;
    logic       ovf;
    logic [3:0] starved;

    int checks = 0;
    int errors = 0;

    credit_sched dut (
        .clk           (clk),
        .rst           (rst),
        .reinit        (reinit),
        .initial_value (initial_value),
        .req_valid     (req_valid),
        .req_amt       (req_amt),
        .req_ready     (req_ready),
        .ret_valid     (ret_valid),
        .ret_amt       (ret_amt),
        .value         (value),
        .value_next    (value_next),
        .ovf           (ovf),
        .starved       (starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then leave 1 time unit before inputs change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; reinit = 1'b0; initial_value = 4'd5;
        req_valid = 4'b0000; req_amt = 8'h00; ret_valid = 1'b0; ret_amt = 2'd0;
        tick();
        req_valid = 4'b1111; req_amt = 8'b01_01_01_01;
        #1;
        chk("rst_value", 32'(value), 32'd5);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_starved", 32'(starved), 32'd0);
        chk("rst_ready_low", 32'(req_ready), 32'd0);

        // Round robin 0,1,2,3 with amount 1 each
        rst = 1'b1;
        #1;
        chk("rr_ready0", 32'(req_ready), 32'b0001);
        chk("rr_next0", 32'(value_next), 32'd4);
        tick();
        chk("rr_value1", 32'(value), 32'd4);
        chk("rr_ready1", 32'(req_ready), 32'b0010);
        tick();
        chk("rr_value2", 32'(value), 32'd3);
        chk("rr_ready2", 32'(req_ready), 32'b0100);
        tick();
        chk("rr_value3", 32'(value), 32'd2);
        chk("rr_ready3", 32'(req_ready), 32'b1000);
        tick();
        chk("rr_value4", 32'(value), 32'd1);
        req_valid = 4'b0000;

        // Reinit to 2, then req0 amt3 loses to req1 amt2
        reinit = 1'b1; initial_value = 4'd2;
        #1;
        chk("reinit_next", 32'(value_next), 32'd2);
        tick();
        reinit = 1'b0;
        req_valid = 4'b0011; req_amt = 8'b00_00_10_11;
        #1;
        chk("elig_ready", 32'(req_ready), 32'b0010);
        chk("elig_next", 32'(value_next), 32'd0);
        tick();
        chk("elig_value", 32'(value), 32'd0);
        chk("elig_req0_wait", 32'(req_ready), 32'd0);
        req_valid = 4'b0000;

        // Return overflow saturates and sets sticky ovf; reinit clears it
        reinit = 1'b1; initial_value = 4'd14;
        tick();
        reinit = 1'b0; ret_valid = 1'b1; ret_amt = 2'd3;
        #1;
        chk("sat_next", 32'(value_next), 32'd15);
        chk("sat_ovf_pre", 32'(ovf), 32'd0);
        tick();
        ret_valid = 1'b0;
        #1;
        chk("sat_value", 32'(value), 32'd15);
        chk("ovf_set", 32'(ovf), 32'd1);
        tick();
        chk("ovf_sticky", 32'(ovf), 32'd1);
        reinit = 1'b1; initial_value = 4'd7; ret_valid = 1'b1; ret_amt = 2'd3;
        #1;
        chk("reinit_ret_ignored", 32'(value_next), 32'd7);
        tick();
        reinit = 1'b0; ret_valid = 1'b0;
        #1;
        chk("reinit_value", 32'(value), 32'd7);
        chk("reinit_ovf_clr", 32'(ovf), 32'd0);

        // Grant and return in the same cycle (pointer is at 1, so req2 is searched first)
        reinit = 1'b1; initial_value = 4'd1;
        tick();
        reinit = 1'b0;
        req_valid = 4'b0100; req_amt = 8'b00_01_00_00; ret_valid = 1'b1; ret_amt = 2'd2;
        #1;
        chk("gr_ret_ready", 32'(req_ready), 32'b0100);
        chk("gr_ret_next", 32'(value_next), 32'd2);
        tick();
        ret_valid = 1'b0;
        chk("gr_ret_value", 32'(value), 32'd2);

        // Zero amounts always eligible; pointer at 2 so requester 3 wins
        req_valid = 4'b1111; req_amt = 8'h00;
        #1;
        chk("rr_after_ptr2", 32'(req_ready), 32'b1000);
        chk("zero_amt_next", 32'(value_next), 32'd2);
        tick();
        req_valid = 4'b0010;
        tick();

        // Mid-stream reset: no grant while low, then requester 0 first
        rst = 1'b0; initial_value = 4'd9; req_valid = 4'b1111;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_value", 32'(value), 32'd9);
        chk("midrst_first", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        tick();

`ifdef CREDIT_SCHED_AGING_EN
        // req0 amt3 waits while req1 amt1 keeps winning with one credit returned per cycle
        reinit = 1'b1; initial_value = 4'd1;
        tick();
        reinit = 1'b0;
        req_valid = 4'b0011; req_amt = 8'b00_00_01_11; ret_valid = 1'b1; ret_amt = 2'd1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("age_starved", 32'(starved), (k == 8) ? 32'b0001 : 32'd0);
        end
        chk("age_block", 32'(req_ready), 32'd0);
        chk("age_accum", 32'(value_next), 32'd2);
        tick();
        chk("age_block2", 32'(req_ready), 32'd0);
        tick();
        chk("age_value3", 32'(value), 32'd3);
        chk("age_grant0", 32'(req_ready), 32'b0001);
        chk("age_next", 32'(value_next), 32'd1);
        tick();
        chk("age_clear", 32'(starved[0]), 32'd0);
        req_valid = 4'b0000; ret_valid = 1'b0;
`else
        chk("starved_tied", 32'(starved), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
